// File: rtl/ram_pkg.sv
// Shared constants and types for the backing-store RAM.
// Optional feature macro: RAM_WRITE_FIRST_EN (write-through on same-address read+write).
package ram_pkg;

    localparam int RAM_ADDR_W = 10;
    localparam int RAM_DATA_W = 32;

    typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
    typedef logic [RAM_DATA_W-1:0] ram_word_t;

    // Number of words addressed by an address of the given width.
    function automatic int unsigned ram_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/ram_if.sv
// Access bus of the backing-store RAM: strobes, shared address, write and read data.
// Optional feature macro: RAM_WRITE_FIRST_EN (affects only the RAM behaviour, not this bus).
interface ram_if
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
);

    logic              write_enable;
    logic              read_enable;
    logic [ADDR_W-1:0] adress;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport master (
        output write_enable,
        output read_enable,
        output adress,
        output data_in,
        input  data_out
    );

    modport slave (
        input  write_enable,
        input  read_enable,
        input  adress,
        input  data_in,
        output data_out
    );

endinterface

// File: rtl/ram_valid_bits.sv
// One valid flag per RAM word. Cleared wholesale by reset so stale array
// contents read as zero; set when the word is written; looked up by address.
// Optional feature macro: RAM_WRITE_FIRST_EN (not used here).
module ram_valid_bits
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              gen_reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] addr,
    output logic              is_valid
);

    localparam int unsigned DEPTH = ram_depth(ADDR_W);

    logic [DEPTH-1:0] valid_q;

    // Clear every flag on reset; mark the addressed word valid on a write.
    always_ff @(posedge clk or posedge gen_reset) begin
        if (gen_reset) begin
            valid_q <= '0;
        end else if (set_en) begin
            valid_q[addr] <= 1'b1;
        end
    end

    assign is_valid = valid_q[addr];

endmodule

// File: rtl/ram.sv
// Single-port synchronous RAM with registered read data and a valid mask.
// Reset does not scrub the data array; the valid flags hide old contents instead.
// Optional feature macro: RAM_WRITE_FIRST_EN. When defined, a read and write to
// the same address in one cycle returns the new write data; otherwise read-first.
module ram
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic clk,
    input  logic gen_reset,
    ram_if.slave bus
);

    localparam int unsigned DEPTH = ram_depth(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              word_valid;
    logic [DATA_W-1:0] stored_word;
    logic [DATA_W-1:0] read_word;
    logic [DATA_W-1:0] data_out_q;

    ram_valid_bits #(
        .ADDR_W (ADDR_W)
    ) u_valid_bits (
        .clk       (clk),
        .gen_reset (gen_reset),
        .set_en    (bus.write_enable),
        .addr      (bus.adress),
        .is_valid  (word_valid)
    );

    assign stored_word = mem[bus.adress];

    // Select the word a read would return this cycle; unwritten words read as zero.
    always_comb begin
        read_word = word_valid ? stored_word : '0;
`ifdef RAM_WRITE_FIRST_EN
        if (bus.write_enable) begin
            read_word = bus.data_in;
        end
`endif
    end

    // Data array write; a strobe coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!gen_reset && bus.write_enable) begin
            mem[bus.adress] <= bus.data_in;
        end
    end

    // Output register: zero on reset, loads only on a read strobe, otherwise holds.
    always_ff @(posedge clk or posedge gen_reset) begin
        if (gen_reset) begin
            data_out_q <= '0;
        end else if (bus.read_enable) begin
            data_out_q <= read_word;
        end
    end

    assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_ram.sv
// Directed self-checking bench for the backing-store RAM.
// Optional feature macro: RAM_WRITE_FIRST_EN changes the expected collision result.
module tb_ram;
    import ram_pkg::*;

    logic clk;
    logic gen_reset;
    int   check_count;
    int   pass_count;
    int   fail_count;

    ram_if #(.ADDR_W(RAM_ADDR_W), .DATA_W(RAM_DATA_W)) bus ();

    ram #(
        .ADDR_W (RAM_ADDR_W),
        .DATA_W (RAM_DATA_W)
    ) dut (
        .clk       (clk),
        .gen_reset (gen_reset),
        .bus       (bus.slave)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of strobes/address/data, then settle 1 unit past the edge.
    task automatic applyStimulus(input logic we, input logic re,
                                 input ram_addr_t addr, input ram_word_t din);
        bus.write_enable = we;
        bus.read_enable  = re;
        bus.adress       = addr;
        bus.data_in      = din;
        @(posedge clk);
        #1;
    endtask

    // Compare data_out with the hand-computed value.
    task automatic checkOutput(input string tag, input ram_word_t expected);
        check_count++;
        assert (bus.data_out === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, bus.data_out, expected);
        end
    endtask

    initial begin
        check_count      = 0;
        pass_count       = 0;
        fail_count       = 0;
        gen_reset        = 1'b1;
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
        bus.adress       = '0;
        bus.data_in      = '0;

        // Reset held across one edge.
        @(posedge clk);
        #1;
        checkOutput("reset_state", 32'd0);
        gen_reset = 1'b0;

        // Read of a never-written word.
        applyStimulus(1'b0, 1'b1, 10'h003, 32'd0);
        checkOutput("read_after_reset_003", 32'd0);

        // Write then read back, plus a neighbouring unwritten word.
        applyStimulus(1'b1, 1'b0, 10'h011, 32'd15);
        applyStimulus(1'b0, 1'b1, 10'h011, 32'd0);
        checkOutput("read_011", 32'd15);
        applyStimulus(1'b0, 1'b1, 10'h012, 32'd0);
        checkOutput("read_012_unwritten", 32'd0);

        // Same-address read+write collision.
        applyStimulus(1'b1, 1'b1, 10'h02C, 32'd25);
`ifdef RAM_WRITE_FIRST_EN
        checkOutput("collision_02c", 32'd25);
`else
        checkOutput("collision_02c", 32'd0);
`endif
        applyStimulus(1'b0, 1'b1, 10'h02C, 32'd0);
        checkOutput("read_02c_after_collision", 32'd25);

        // Hold: output keeps its value with both strobes low.
        applyStimulus(1'b1, 1'b0, 10'h041, 32'd35);
        applyStimulus(1'b0, 1'b1, 10'h041, 32'd0);
        checkOutput("read_041", 32'd35);
        applyStimulus(1'b0, 1'b0, 10'h020, 32'd80);
        checkOutput("hold_cycle1", 32'd35);
        applyStimulus(1'b0, 1'b0, 10'h020, 32'd80);
        checkOutput("hold_cycle2", 32'd35);
        applyStimulus(1'b1, 1'b0, 10'h050, 32'd7);
        checkOutput("hold_during_write", 32'd35);
        applyStimulus(1'b0, 1'b1, 10'h020, 32'd0);
        checkOutput("read_020_never_written", 32'd0);
        applyStimulus(1'b0, 1'b1, 10'h050, 32'd0);
        checkOutput("read_050", 32'd7);

        // Boundary addresses.
        applyStimulus(1'b1, 1'b0, 10'h3FF, 32'd100);
        applyStimulus(1'b1, 1'b0, 10'h01F, 32'd20);
        applyStimulus(1'b0, 1'b1, 10'h3FF, 32'd0);
        checkOutput("read_3ff", 32'd100);
        applyStimulus(1'b0, 1'b1, 10'h01F, 32'd0);
        checkOutput("read_01f", 32'd20);
        applyStimulus(1'b0, 1'b1, 10'h000, 32'd0);
        checkOutput("read_000", 32'd0);
        applyStimulus(1'b0, 1'b1, 10'h3FF, 32'd0);
        checkOutput("reread_3ff", 32'd100);

        // Mid-run reset clears the output without waiting for a clock edge.
        gen_reset = 1'b1;
        #1;
        checkOutput("async_reset_immediate", 32'd0);
        applyStimulus(1'b1, 1'b1, 10'h060, 32'd55);
        checkOutput("strobe_during_reset", 32'd0);
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
        gen_reset        = 1'b0;

        // Everything written before the reset now reads as zero.
        applyStimulus(1'b0, 1'b1, 10'h011, 32'd0);
        checkOutput("read_011_after_reset", 32'd0);
        applyStimulus(1'b0, 1'b1, 10'h060, 32'd0);
        checkOutput("read_060_write_in_reset", 32'd0);
        applyStimulus(1'b0, 1'b1, 10'h3FF, 32'd0);
        checkOutput("read_3ff_after_reset", 32'd0);

        // Writes work again after reset release.
        applyStimulus(1'b1, 1'b0, 10'h011, 32'd99);
        applyStimulus(1'b0, 1'b1, 10'h011, 32'd0);
        checkOutput("read_011_rewritten", 32'd99);

        applyStimulus(1'b0, 1'b0, 10'h000, 32'd0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
